// File: rtl/uart_mem_master.sv
// Memory-access execution stage for the UART command peripheral (DO_MEM_WRITE / DO_MEM_READ).
// Defining UART_MEM_TIMEOUT_EN adds a bus-grant timeout that aborts the sequence and pulses err.
module uart_mem_master #(
    parameter int ADDR_W         = 32,
    parameter int CNT_W          = 7,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_enable,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              mem_req,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_WAIT, S_WR_REQ, S_RD_REQ, S_RD_SEND, S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_wdata;
    logic [7:0]        r_tx_data;
    logic              r_cmd_ready;
    logic              r_tx_enable;
    logic              r_mem_req;
    logic              r_mem_wen;
    logic              r_done;
    logic              w_timeout;

`ifdef UART_MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait;
    logic          r_err;

    // mem_req always drops between accesses, so clearing while idle restarts the count per access
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_wait <= '0;
        else if (!r_mem_req)
            r_wait <= '0;
        else if (!mem_gnt)
            r_wait <= r_wait + 1'b1;
    end

    assign w_timeout = r_mem_req && !mem_gnt && (r_wait == TW'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_wdata     <= '0;
            r_tx_data   <= '0;
            r_cmd_ready <= 1'b1;
            r_tx_enable <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_done      <= 1'b0;
`ifdef UART_MEM_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef UART_MEM_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= cmd_addr;
                        r_cnt       <= cmd_count;
                        r_cmd_ready <= 1'b0;
                        if (cmd_count == '0) begin
                            r_state <= S_DONE;
                        end else if (cmd_write) begin
                            r_state <= S_WR_WAIT;
                        end else begin
                            r_state   <= S_RD_REQ;
                            r_mem_req <= 1'b1;
                            r_mem_wen <= 1'b0;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (rx_valid) begin
                        r_wdata   <= rx_data;
                        r_mem_req <= 1'b1;
                        r_mem_wen <= 1'b1;
                        r_state   <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_mem_wen <= 1'b0;
                        r_addr    <= r_addr + 1'b1;
                        r_cnt     <= r_cnt - 1'b1;
                        r_state   <= (r_cnt == CNT_W'(1)) ? S_DONE : S_WR_WAIT;
                    end else if (w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_mem_wen   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
`ifdef UART_MEM_TIMEOUT_EN
                        r_err       <= 1'b1;
`endif
                    end
                end
                S_RD_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req   <= 1'b0;
                        r_tx_data   <= mem_rdata;
                        r_tx_enable <= 1'b1;
                        r_state     <= S_RD_SEND;
                    end else if (w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
`ifdef UART_MEM_TIMEOUT_EN
                        r_err       <= 1'b1;
`endif
                    end
                end
                S_RD_SEND: begin
                    if (!tx_busy) begin
                        r_tx_enable <= 1'b0;
                        r_addr      <= r_addr + 1'b1;
                        r_cnt       <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state   <= S_RD_REQ;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_mem_req   <= 1'b0;
                    r_tx_enable <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign tx_enable = r_tx_enable;
    assign tx_data   = r_tx_data;
    assign mem_req   = r_mem_req;
    assign mem_wen   = r_mem_wen;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cur_addr  = r_addr;
    assign done      = r_done;

endmodule

// File: tb/tb_uart_mem_master.sv
// Self-checking bench for uart_mem_master: vector table plus hand-written corner sequences.
// Bus/UART expectations are queued when a command is issued and popped as the DUT performs them.
module tb_uart_mem_master;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [6:0]  cmd_count = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        tx_enable;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_gnt = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [31:0] cur_addr;
    logic        done;
    logic        err;

    uart_mem_master #(.ADDR_W(32), .CNT_W(7), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_count(cmd_count),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_enable(tx_enable), .tx_data(tx_data), .tx_busy(tx_busy),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .cur_addr(cur_addr), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [6:0]  cnt;
        logic [31:0] d;
        int          lat;
        logic [31:0] exp_cur;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [7:0]  data;
    } bus_t;

    vec_t        vecs[7];
    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    bus_t        e_bus;

    int checks = 0;
    int failures = 0;
    int gnt_lat = 1;
    bit gnt_en = 1'b1;
    int req_cnt = 0;
    int bus_cnt = 0;
    int bus_idx = 0;
    int tx_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int req_hi = 0;
    logic [31:0] cur_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder and output monitors, all sampling on the falling edge.
    always @(negedge clk) begin
        if (mem_req) req_hi++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (tx_enable && !tx_busy) begin
            tx_cnt++;
            check("tx_expected", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) check("tx_data", tx_data, exp_tx.pop_front());
        end
        if (mem_gnt) begin
            mem_gnt = 1'b0;
            req_cnt = 0;
        end else if (mem_req && gnt_en) begin
            req_cnt++;
            if (req_cnt >= gnt_lat) begin
                mem_gnt   = 1'b1;
                mem_rdata = cur_data[8*(bus_idx%4) +: 8];
                check("bus_expected", exp_bus.size() != 0, 1);
                if (exp_bus.size() != 0) begin
                    e_bus = exp_bus.pop_front();
                    check("bus_addr", mem_addr, e_bus.addr);
                    check("bus_wen", mem_wen, e_bus.wen);
                    if (e_bus.wen) check("bus_wdata", mem_wdata, e_bus.data);
                end
                bus_cnt++;
                bus_idx++;
            end
        end else begin
            req_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        while (done_cnt == 0 && t < limit) begin
            tick();
            t++;
        end
    endtask

    task automatic start_cmd(input logic wr, input logic [31:0] a, input logic [6:0] n);
        check("cmd_ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_count = n;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic clear_counts();
        bus_cnt = 0; bus_idx = 0; tx_cnt = 0; done_cnt = 0; req_hi = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        clear_counts();
        cur_data = v.d;
        gnt_lat  = v.lat;
        for (int k = 0; k < int'(v.cnt); k++) begin
            exp_bus.push_back('{v.addr + 32'(k), v.wr, v.wr ? v.d[8*k +: 8] : 8'h00});
            if (!v.wr) exp_tx.push_back(v.d[8*k +: 8]);
        end
        start_cmd(v.wr, v.addr, v.cnt);
        if (v.wr) begin
            for (int k = 0; k < int'(v.cnt); k++) begin
                rx_valid = 1'b1;
                rx_data  = v.d[8*k +: 8];
                tick();
                rx_valid = 1'b0;
                t = 0;
                while (bus_cnt <= k && t < 100) begin
                    tick();
                    t++;
                end
            end
        end
        wait_done(500);
        tick();
        tick();
        check("vec_done_once", done_cnt, 1);
        check("vec_cur_addr", cur_addr, v.exp_cur);
        check("vec_bus_count", bus_cnt, v.cnt);
        check("vec_tx_count", tx_cnt, v.wr ? 0 : int'(v.cnt));
        check("vec_bus_drained", exp_bus.size(), 0);
        check("vec_tx_drained", exp_tx.size(), 0);
        check("vec_no_req_iff_zero", req_hi == 0, v.cnt == 0);
        check("vec_cmd_ready_after", cmd_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        int   t;

        vecs[0] = '{1'b0, 32'h0000_1000, 7'd3, 32'h0033_2211, 2, 32'h0000_1003};
        vecs[1] = '{1'b1, 32'h0000_0020, 7'd2, 32'h0000_5AA5, 1, 32'h0000_0022};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 7'd2, 32'h0000_3CC3, 1, 32'h0000_0001};
        vecs[3] = '{1'b1, 32'hFFFF_FFFE, 7'd3, 32'h0003_0201, 3, 32'h0000_0001};
        vecs[4] = '{1'b0, 32'h0000_0007, 7'd1, 32'h0000_0080, 1, 32'h0000_0008};
        vecs[5] = '{1'b1, 32'h0000_0055, 7'd0, 32'h0000_0000, 1, 32'h0000_0055};
        vecs[6] = '{1'b0, 32'h0000_0099, 7'd0, 32'h0000_0000, 1, 32'h0000_0099};

        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_tx_enable", tx_enable, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cur_addr", cur_addr, 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // count=0: done is high exactly in the second cycle after the accept cycle
        clear_counts();
        start_cmd(1'b0, 32'h0000_0077, 7'd0);
        check("cnt0_done_c1", done, 0);
        check("cnt0_busy_c1", cmd_ready, 0);
        tick();
        check("cnt0_done_c2", done, 1);
        check("cnt0_ready_c2", cmd_ready, 1);
        tick();
        check("cnt0_done_c3", done, 0);
        check("cnt0_no_req", req_hi, 0);
        check("cnt0_cur_addr", cur_addr, 32'h77);

        // transmitter busy for 50 cycles; stray rx bytes must not cause writes
        clear_counts();
        cur_data = 32'h0000_CDAB;
        gnt_lat  = 1;
        exp_bus.push_back('{32'h300, 1'b0, 8'h00});
        exp_bus.push_back('{32'h301, 1'b0, 8'h00});
        exp_tx.push_back(8'hAB);
        exp_tx.push_back(8'hCD);
        tx_busy = 1'b1;
        start_cmd(1'b0, 32'h0000_0300, 7'd2);
        t = 0;
        while (!tx_enable && t < 50) begin
            tick();
            t++;
        end
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rx_valid = (i % 5 == 0);
            rx_data  = 8'hEE;
            if (!(tx_enable === 1'b1 && tx_data === 8'hAB)) stable = 1'b0;
            tick();
        end
        rx_valid = 1'b0;
        check("busy_hold_stable", stable, 1);
        check("busy_no_accept", tx_cnt, 0);
        tx_busy = 1'b0;
        tick();
        check("busy_accept_first", tx_cnt, 1);
        check("busy_tx_en_drop", tx_enable, 0);
        wait_done(200);
        tick();
        check("busy_done_once", done_cnt, 1);
        check("busy_tx_count", tx_cnt, 2);
        check("busy_bus_count", bus_cnt, 2);
        check("busy_cur_addr", cur_addr, 32'h302);

        // rx byte coinciding with the WR_REQ -> WR_WAIT edge is dropped
        clear_counts();
        gnt_lat = 2;
        exp_bus.push_back('{32'h40, 1'b1, 8'h11});
        exp_bus.push_back('{32'h41, 1'b1, 8'h22});
        start_cmd(1'b1, 32'h0000_0040, 7'd2);
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        tick();
        rx_valid = 1'b0;
        check("drop_req_seen", mem_req, 1);
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        tick();
        rx_valid = 1'b0;
        check("drop_first_written", bus_cnt, 1);
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'h22;
        tick();
        rx_valid = 1'b0;
        wait_done(100);
        tick();
        check("drop_done_once", done_cnt, 1);
        check("drop_bus_count", bus_cnt, 2);
        check("drop_cur_addr", cur_addr, 32'h42);
        check("drop_bus_drained", exp_bus.size(), 0);

        // asynchronous reset while a write request is outstanding
        clear_counts();
        gnt_en = 1'b0;
        start_cmd(1'b1, 32'h0000_0050, 7'd1);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        tick();
        rx_valid = 1'b0;
        check("rstmid_req_before", mem_req, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("rstmid_req_dropped", mem_req, 0);
        check("rstmid_cmd_ready", cmd_ready, 1);
        check("rstmid_cur_addr", cur_addr, 0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        check("rstmid_ready_after", cmd_ready, 1);
        check("rstmid_no_req_after", mem_req, 0);
        check("rstmid_no_access", bus_cnt, 0);
        check("rstmid_no_done", done_cnt, 0);

`ifdef UART_MEM_TIMEOUT_EN
        clear_counts();
        err_cnt = 0;
        start_cmd(1'b0, 32'h0000_0060, 7'd1);
        t = 0;
        while (err_cnt == 0 && t < 400) begin
            tick();
            t++;
        end
        tick();
        tick();
        check("to_req_cycles", req_hi, 255);
        check("to_err_once", err_cnt, 1);
        check("to_no_done", done_cnt, 0);
        check("to_cur_addr", cur_addr, 32'h60);
        check("to_cmd_ready", cmd_ready, 1);
        check("to_req_low", mem_req, 0);
`else
        repeat (20) tick();
        check("err_never", err_cnt, 0);
`endif
        gnt_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_mem_master.md
Name: uart_mem_master

Overview:
- Downstream execution stage of the UART command peripheral. Executes the DO_MEM_WRITE (0xD0) and DO_MEM_READ (0xD1) commands.
- Takes a start address and byte count from the command decoder and runs byte-wide memory bus transactions.
- Write data comes from the UART receiver byte stream; read data goes back out through the UART transmitter.
- Reports completion, and optionally a bus timeout, to the command FSM.

Parameters:
- ADDR_W, 32, memory address width.
- CNT_W, 7, access count width; matches the command peripheral's access-count register.
- TIMEOUT_CYCLES, 255, cycles to wait for mem_gnt before aborting (only used with UART_MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  start request from command FSM
- cmd_ready  out  1  high when idle; command accepted on cmd_valid && cmd_ready
- cmd_write  in  1  1 = memory write sequence, 0 = memory read sequence
- cmd_addr  in  ADDR_W  start address
- cmd_count  in  CNT_W  number of byte accesses
- rx_valid  in  1  single-cycle pulse, received byte available
- rx_data  in  8  received byte
- tx_enable  out  1  request transmission of tx_data
- tx_data  out  8  byte to transmit
- tx_busy  in  1  transmitter busy
- mem_req  out  1  bus request
- mem_wen  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  8  write data
- mem_gnt  in  1  transfer completes this cycle
- mem_rdata  in  8  read data, valid when mem_gnt && !mem_wen
- cur_addr  out  ADDR_W  next address; written back to the peripheral's address register
- done  out  1  single-cycle pulse, sequence complete
- err  out  1  single-cycle pulse, sequence aborted on timeout

Behaviour:
- Reset (asynchronous):
  - State = IDLE.
  - All outputs 0 except cmd_ready = 1.
  - Address, count, data and timeout registers cleared.
  - Reset mid-sequence drops mem_req and tx_enable immediately; no further accesses occur.
- States: IDLE, WR_WAIT, WR_REQ, RD_REQ, RD_SEND, DONE.
- IDLE: cmd_ready = 1. On accept, latch cmd_addr into addr and cmd_count into cnt, then branch:
  - cnt == 0 -> DONE (no bus or UART activity).
  - cmd_write = 1 -> WR_WAIT.
  - cmd_write = 0 -> RD_REQ.
- WR_WAIT: on rx_valid, latch rx_data into wdata, go to WR_REQ.
- WR_REQ:
  - mem_req = 1, mem_wen = 1, mem_addr = addr, mem_wdata = wdata, all held stable until mem_gnt.
  - On mem_gnt: addr += 1, cnt -= 1. Go to DONE if the new cnt is 0, else WR_WAIT.
- RD_REQ:
  - mem_req = 1, mem_wen = 0, mem_addr = addr.
  - On mem_gnt: latch mem_rdata into tx_data, go to RD_SEND.
- RD_SEND:
  - tx_enable = 1 with tx_data held.
  - Byte is accepted on the first cycle with tx_busy = 0. tx_enable drops the next cycle.
  - On acceptance: addr += 1, cnt -= 1. Go to DONE if cnt is 0, else RD_REQ.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Address arithmetic: addr increments modulo 2^ADDR_W, so 0xFFFFFFFF wraps to 0x00000000.
- cur_addr = addr at all times.
- mem_req is never asserted in two consecutive transactions without an intervening non-REQ state.
- Ignored inputs:
  - rx_valid outside WR_WAIT is ignored (byte dropped).
  - cmd_valid while not idle is ignored.
- Simultaneous rx_valid and the WR_REQ -> WR_WAIT transition in the same cycle: the byte is dropped, because it arrives before WR_WAIT is entered.
- Latency:
  - Write byte: rx_valid -> mem_req is 1 cycle.
  - Read: mem_gnt -> tx_enable is 1 cycle.

Optional Feature:
- Macro UART_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WR_REQ/RD_REQ and increments each cycle mem_req = 1 && mem_gnt = 0.
  - When it reaches TIMEOUT_CYCLES: mem_req drops, err pulses for one cycle, state returns to IDLE, done is not pulsed.
  - addr/cur_addr keep the address of the failed access.
- Not defined: no counter, REQ states wait indefinitely, err is tied to 0.

Test Plan:
- Read, count=3, addr=0x00001000, memory holds 0x11, 0x22, 0x33, mem_gnt 2 cycles after each req -> three mem_req reads at 0x1000, 0x1001, 0x1002; tx bytes 0x11, 0x22, 0x33 in order; done pulses once; cur_addr=0x1003.
- Write, count=2, addr=0x20, rx bytes 0xA5 then 0x5A -> mem writes (0x20, 0xA5) and (0x21, 0x5A); done pulses; cur_addr=0x22.
- count=0 (read and write) -> no mem_req, no tx_enable; done pulses 2 cycles after cmd accept.
- Read at addr=0xFFFFFFFF, count=2 -> accesses at 0xFFFFFFFF then 0x00000000; cur_addr=0x00000001.
- Read with tx_busy held high 50 cycles -> tx_enable and tx_data stable throughout; byte accepted on first tx_busy=0 cycle; rx_valid pulses during the read are ignored.
- resetn low during WR_REQ -> mem_req low immediately; cmd_ready=1 after release. With UART_MEM_TIMEOUT_EN and mem_gnt never asserted -> err pulses after exactly 255 request cycles, no done, state returns to IDLE.
